seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_if.sv | 29 ++
 rtl/seg_bcd_decode.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the 7-segment scan controller.
//   SEG_BLANK     all segments dark (active-low bus)
//   SEG_DIGIT     active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
//   scan_state_t  scan FSM states
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if -- control and display-pin bundle of the scan controller.
//   enable      1 = scan, 0 = display dark
//   load        1-cycle strobe capturing digits_in into the pending register
//   digits_in   BCD digits, digit k = [4k+3:4k], digit 0 least significant
//   anode_n     active-low digit select, at most one bit low
//   segments    {g,f,e,d,c,b,a}, 0 = lit
//   frame_done  1-cycle pulse when the last digit slot ends
// master: the logic feeding digits (drives enable/load/digits_in).
// slave:  the scan controller (drives the display pins).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic [6:0]                segments;
  logic                      frame_done;

  modport master (
    output enable, load, digits_in,
    input  anode_n, segments, frame_done
  );

  modport slave (
    input  enable, load, digits_in,
    output anode_n, segments, frame_done
  );
endinterface

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode -- combinational BCD to active-low 7-segment decoder.
//   bcd  in   4  BCD digit
//   seg  out  7  {g,f,e,d,c,b,a}, 0 = lit; codes 10..15 decode to all dark
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexes NUM_DIGITS BCD digits onto one shared
// active-low 7-segment bus with per-digit active-low anodes.
// Each digit slot lasts REFRESH_DIV clocks; the first BLANK_CYCLES of it keep
// every anode off so the previous digit cannot ghost onto the next one.
// Digits are loaded into a pending register and only copied to the displayed
// (active) register at frame start, so a frame never mixes old and new values.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (display dark immediately)
//   bus    seg_scan_ctrl_if.slave: enable, load, digits_in in;
//          anode_n, segments, frame_done out (all registered)
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//   significant nonzero digit are shown dark (digit 0 is always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(REFRESH_DIV - 1);

  scan_state_t               state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   pending;
  logic [4*NUM_DIGITS-1:0]   active;
  logic [NUM_DIGITS-1:0]     anode_r;
  logic [6:0]                seg_r;
  logic                      frame_done_r;

  logic [3:0]                cur_bcd;
  logic [6:0]                cur_seg;
  logic                      frame_end;
  logic                      frame_start;

  assign cur_bcd = active[4*int'(idx) +: 4];

  seg_bcd_decode u_decode (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  assign frame_end   = (state == DRIVE) && (cnt == SLOT_END) && (idx == LAST_IDX);
  // Entering the digit-0 blank slot, either from idle or by wrapping the index.
  assign frame_start = bus.enable && ((state == IDLE) || frame_end);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            shown_seg;

  // Bit k set when digit k and every digit above it are zero; digit 0 never masked.
  function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] mask;
    logic                  seen;
    mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'd0) seen = 1'b1;
      mask[k] = ~seen;
    end
    return mask;
  endfunction

  assign shown_seg = lz_mask[idx] ? SEG_BLANK : cur_seg;

  // Mask is taken from the same value copied into active, so it stays frame-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_mask <= '0;
    end else if (frame_start) begin
      lz_mask <= lz_blank_mask(pending);
    end
  end
`else
  logic [6:0] shown_seg;
  assign shown_seg = cur_seg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      pending      <= '0;
      active       <= '0;
      anode_r      <= '1;
      seg_r        <= SEG_BLANK;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.load) pending <= bus.digits_in;
      // Old pending value is copied, so a load on this same edge waits a frame.
      if (frame_start) active <= pending;

      // Pins reflect the current state/index, one clock behind the FSM.
      frame_done_r <= frame_end && bus.enable;
      if (state == DRIVE) begin
        anode_r <= ~(NUM_DIGITS'(1) << idx);
        seg_r   <= shown_seg;
      end else begin
        anode_r <= '1;
        seg_r   <= SEG_BLANK;
      end

      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_END) state <= DRIVE;
          end
          DRIVE: begin
            if (cnt == SLOT_END) begin
              cnt   <= '0;
              state <= BLANK;
              idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.anode_n    = anode_r;
  assign bus.segments   = seg_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl -- scoreboard bench for seg_scan_ctrl with
// NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// The stimulus thread queues the expected lit slots (anode, segments, lit
// length, preceding dark gap); a monitor pops one entry per lit slot it sees.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SZ = 7'b1111111;
`else
  localparam logic [6:0] SZ = 7'b1000000;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         len;
    int         dark;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_chk;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input int len, input int dark);
    exp_t e;
    e.an = an; e.seg = seg; e.len = len; e.dark = dark;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int dark0);
    push(4'b1110, s0, 6, dark0);
    push(4'b1101, s1, 6, 2);
    push(4'b1011, s2, 6, 2);
    push(4'b0111, s3, 6, 2);
  endtask

  task automatic load_digits(input logic [15:0] v);
    bus.digits_in = v;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    bus.digits_in = 16'hFFFF;
  endtask

  task automatic wait_fd(input int n, input string name);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus.frame_done) seen++;
    end
    if (seen < n) begin
      n_chk++;
      $display("FAIL %s: saw %0d frame_done pulses, expected %0d", name, seen, n);
    end
  endtask

  task automatic wait_anode(input logic [3:0] pat, input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.anode_n != pat && cyc < 500);
    if (bus.anode_n != pat) begin
      n_chk++;
      $display("FAIL %s: anode_n %b never reached, last %b", name, pat, bus.anode_n);
    end
  endtask

  // Monitor: one scoreboard entry per lit slot.
  logic [3:0] run_an;
  logic [6:0] run_seg;
  int         run_len;
  int         dark_len;
  bit         in_run;
  bit         seg_var;
  exp_t       cur;

  initial begin
    in_run = 1'b0; seg_var = 1'b0; run_len = 0; dark_len = 0;
    run_an = 4'hF; run_seg = SB;
    cur.an = 4'hF; cur.seg = SB; cur.len = 0; cur.dark = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_run   = 1'b0;
        dark_len = 0;
      end else begin
        if (in_run && bus.anode_n != run_an) begin
          if (cur.len > 0) check("slot_len", 32'(run_len), 32'(cur.len));
          check("slot_steady", 32'(seg_var), 32'(0));
          in_run = 1'b0;
        end
        if (bus.anode_n == 4'hF) begin
          dark_len++;
        end else if (!in_run) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_slot: anode_n=%b segments=%b, expected no lit slot",
                     bus.anode_n, bus.segments);
            cur.len = 0;
          end else begin
            cur = exp_q.pop_front();
            check("slot_anode", 32'(bus.anode_n), 32'(cur.an));
            check("slot_seg", 32'(bus.segments), 32'(cur.seg));
            if (cur.dark != 0) check("slot_gap", 32'(dark_len), 32'(cur.dark));
          end
          in_run   = 1'b1;
          run_an   = bus.anode_n;
          run_seg  = bus.segments;
          run_len  = 1;
          seg_var  = 1'b0;
          dark_len = 0;
        end else begin
          run_len++;
          if (bus.segments != run_seg) seg_var = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int fd_seen;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.load = 1'b0;
    bus.digits_in = '0;

    // Reset held with enable high: display stays dark.
    repeat (3) begin
      @(negedge clk);
      check("rst_anode", 32'(bus.anode_n), 32'(4'hF));
      check("rst_seg", 32'(bus.segments), 32'(SB));
      check("rst_fd", 32'(bus.frame_done), 32'(0));
    end
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_digits(16'h1234);

    push_frame(S4, S3, S2, S1, 0);   // F1
    push_frame(S4, S3, S2, S1, 2);   // F2
    push_frame(S4, S3, S2, S1, 2);   // F3 (9999 loaded mid-frame)
    push_frame(S9, S9, S9, S9, 2);   // F4
    push_frame(S5, SB, SZ, SZ, 2);   // F5 (00A5)
    push(4'b1110, S5, 6, 2);         // F6 digit 0
    push(4'b1101, SB, 2, 2);         // F6 digit 1 cut short by enable drop

    bus.enable = 1'b1;
    wait_fd(1, "wait_f1");
    @(negedge clk);
    check("fd_width", 32'(bus.frame_done), 32'(0));
    cnt = 1;
    while (!bus.frame_done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("frame_period", 32'(cnt), 32'(32));

    wait_anode(4'b1011, "f3_digit2");
    load_digits(16'h9999);
    wait_fd(1, "wait_f3");
    wait_anode(4'b1011, "f4_digit2");
    load_digits(16'h00A5);
    wait_fd(2, "wait_f5");
    wait_anode(4'b1101, "f6_digit1");
    bus.enable = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("drop_anode", 32'(bus.anode_n), 32'(4'hF));
    fd_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.frame_done) fd_seen++;
    end
    check("idle_fd", 32'(fd_seen), 32'(0));
    check("idle_seg", 32'(bus.segments), 32'(SB));
    check("queue_drained_f6", 32'(exp_q.size()), 32'(0));

    push_frame(S5, SB, SZ, SZ, 0);   // F7: active reloaded from pending 00A5
    push_frame(S0, S7, SZ, SZ, 2);   // F8 (0070)
    push_frame(S0, SZ, SZ, SZ, 2);   // F9 (0000)

    bus.enable = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.anode_n == 4'hF && cnt < 50);
    check("restart_latency", 32'(cnt), 32'(4));

    wait_anode(4'b1011, "f7_digit2");
    load_digits(16'h0070);
    wait_fd(1, "wait_f7");
    wait_anode(4'b1011, "f8_digit2");
    load_digits(16'h0000);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("queue_drained_f9", 32'(exp_q.size()), 32'(0));
    wait_anode(4'hF, "f9_end");
    bus.enable = 1'b0;
    repeat (20) @(negedge clk);
    check("final_anode", 32'(bus.anode_n), 32'(4'hF));
    check("final_fd", 32'(bus.frame_done), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
